// File: rtl/sw_alloc_main_if.sv
// Switch-allocator port bundle: per-input requests/tails, per-output credits,
// per-output crossbar selects and per-input grants. Width set by global macro `N.
`ifndef N
`define N 5
`endif

interface sw_alloc_main_if;
    logic [`N-1:0] req_from_P0;
    logic [`N-1:0] req_from_P1;
    logic [`N-1:0] req_from_P2;
    logic [`N-1:0] req_from_P3;
    logic [`N-1:0] req_from_P4;
    logic          tail_from_P0;
    logic          tail_from_P1;
    logic          tail_from_P2;
    logic          tail_from_P3;
    logic          tail_from_P4;
    logic [`N-1:0] out_ready;
    logic [`N-1:0] sel_for_OP0;
    logic [`N-1:0] sel_for_OP1;
    logic [`N-1:0] sel_for_OP2;
    logic [`N-1:0] sel_for_OP3;
    logic [`N-1:0] sel_for_OP4;
    logic          grant_to_P0;
    logic          grant_to_P1;
    logic          grant_to_P2;
    logic          grant_to_P3;
    logic          grant_to_P4;

    // Router input side: raises requests, consumes selects and grants.
    modport master (
        output req_from_P0, req_from_P1, req_from_P2, req_from_P3, req_from_P4,
        output tail_from_P0, tail_from_P1, tail_from_P2, tail_from_P3, tail_from_P4,
        output out_ready,
        input  sel_for_OP0, sel_for_OP1, sel_for_OP2, sel_for_OP3, sel_for_OP4,
        input  grant_to_P0, grant_to_P1, grant_to_P2, grant_to_P3, grant_to_P4
    );

    modport slave (
        input  req_from_P0, req_from_P1, req_from_P2, req_from_P3, req_from_P4,
        input  tail_from_P0, tail_from_P1, tail_from_P2, tail_from_P3, tail_from_P4,
        input  out_ready,
        output sel_for_OP0, sel_for_OP1, sel_for_OP2, sel_for_OP3, sel_for_OP4,
        output grant_to_P0, grant_to_P1, grant_to_P2, grant_to_P3, grant_to_P4
    );
endinterface

// File: rtl/sw_alloc_main.sv
// Router switch allocator: one round-robin arbiter per output port, registered selects.
// Optional wormhole packet lock per output is compiled in with SW_ALLOC_PKT_LOCK_EN.
`ifndef N
`define N 5
`endif

module sw_alloc_main #(
    parameter int PTR_RST = 0
) (
    input  logic           clk,
    input  logic           rst,
    sw_alloc_main_if.slave sw
);
    localparam int NP = `N;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;

    logic [NP-1:0] req     [NP];   // indexed by input port
    logic [NP-1:0] tail;
    logic [NP-1:0] cand    [NP];   // indexed by output port: which inputs want it
    logic [NP-1:0] sel_reg [NP];
    logic [NP-1:0] sel_t   [NP];   // indexed by input port: which outputs selected it
    logic [PW-1:0] ptr_reg [NP];
    logic [NP-1:0] win_vld;
    logic [PW-1:0] win_idx [NP];
    logic [NP-1:0] win_oh  [NP];
    logic [NP-1:0] grant;

`ifdef SW_ALLOC_PKT_LOCK_EN
    logic [NP-1:0] locked_reg;
    logic [PW-1:0] owner_reg [NP];
`else
    logic unused_tail;
    assign unused_tail = ^tail;
`endif

    assign req[0] = sw.req_from_P0;
    assign req[1] = sw.req_from_P1;
    assign req[2] = sw.req_from_P2;
    assign req[3] = sw.req_from_P3;
    assign req[4] = sw.req_from_P4;
    assign tail   = {sw.tail_from_P4, sw.tail_from_P3, sw.tail_from_P2,
                     sw.tail_from_P1, sw.tail_from_P0};

    assign sw.sel_for_OP0 = sel_reg[0];
    assign sw.sel_for_OP1 = sel_reg[1];
    assign sw.sel_for_OP2 = sel_reg[2];
    assign sw.sel_for_OP3 = sel_reg[3];
    assign sw.sel_for_OP4 = sel_reg[4];
    assign sw.grant_to_P0 = grant[0];
    assign sw.grant_to_P1 = grant[1];
    assign sw.grant_to_P2 = grant[2];
    assign sw.grant_to_P3 = grant[3];
    assign sw.grant_to_P4 = grant[4];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            for (gj = 0; gj < NP; gj++) begin : g_xpose
                assign cand[gi][gj]  = req[gj][gi];
                assign sel_t[gi][gj] = sel_reg[gj][gi];
            end
            assign grant[gi] = |sel_t[gi];

            // A multi-hot request would let one flit win two outputs at once.
            always @(posedge clk) begin
                if (!rst) begin
                    assert ($onehot0(req[gi]));
                end
            end
        end
    endgenerate

    // Per-output search from the pointer, ascending with wrap; a locked output
    // only considers its owner.
    always_comb begin
        logic [NP-1:0] elig;
        int            idx;
        elig = '0;
        idx  = 0;
        for (int o = 0; o < NP; o++) begin
            win_vld[o] = 1'b0;
            win_idx[o] = '0;
            elig       = cand[o];
`ifdef SW_ALLOC_PKT_LOCK_EN
            if (locked_reg[o]) begin
                elig = cand[o] & (NP'(1) << owner_reg[o]);
            end
`endif
            if (sw.out_ready[o]) begin
                for (int k = 0; k < NP; k++) begin
                    idx = int'(ptr_reg[o]) + k;
                    if (idx >= NP) begin
                        idx = idx - NP;
                    end
                    if (!win_vld[o] && elig[idx]) begin
                        win_vld[o] = 1'b1;
                        win_idx[o] = PW'(idx);
                    end
                end
            end
            win_oh[o] = win_vld[o] ? (NP'(1) << win_idx[o]) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NP; o++) begin
                sel_reg[o] <= '0;
                ptr_reg[o] <= PW'(PTR_RST);
`ifdef SW_ALLOC_PKT_LOCK_EN
                locked_reg[o] <= 1'b0;
                owner_reg[o]  <= '0;
`endif
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                sel_reg[o] <= win_oh[o];
                if (win_vld[o]) begin
`ifdef SW_ALLOC_PKT_LOCK_EN
                    // Pointer moves past the winner only once its packet is done.
                    if (tail[win_idx[o]]) begin
                        locked_reg[o] <= 1'b0;
                        ptr_reg[o]    <= (win_idx[o] == PW'(NP - 1)) ? '0
                                                                     : win_idx[o] + PW'(1);
                    end else begin
                        locked_reg[o] <= 1'b1;
                        owner_reg[o]  <= win_idx[o];
                    end
`else
                    ptr_reg[o] <= (win_idx[o] == PW'(NP - 1)) ? '0 : win_idx[o] + PW'(1);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_sw_alloc_main.sv
// Self-checking bench for sw_alloc_main: directed scenarios plus random traffic
// against a per-output round-robin reference model.
`ifndef N
`define N 5
`endif

module tb_sw_alloc_main;
    localparam int NP = `N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sw_alloc_main_if ifc();
    sw_alloc_main #(.PTR_RST(0)) dut (.clk(clk), .rst(rst), .sw(ifc));

    int tests = 0;
    int fails = 0;

    logic [NP-1:0] req_v [NP];
    logic [NP-1:0] tail_v;
    logic [NP-1:0] ready_v;

    // Reference state: pointer and packet owner per output.
    int            m_ptr    [NP];
    bit            m_locked [NP];
    int            m_owner  [NP];
    logic [NP-1:0] exp_sel  [NP];
    logic [NP-1:0] exp_grant;
    logic [NP-1:0] obs_sel  [NP];
    logic [NP-1:0] obs_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs[NP-1:0], exp[NP-1:0]);
        end
    endtask

    task automatic drive();
        ifc.req_from_P0  = req_v[0];
        ifc.req_from_P1  = req_v[1];
        ifc.req_from_P2  = req_v[2];
        ifc.req_from_P3  = req_v[3];
        ifc.req_from_P4  = req_v[4];
        ifc.tail_from_P0 = tail_v[0];
        ifc.tail_from_P1 = tail_v[1];
        ifc.tail_from_P2 = tail_v[2];
        ifc.tail_from_P3 = tail_v[3];
        ifc.tail_from_P4 = tail_v[4];
        ifc.out_ready    = ready_v;
    endtask

    // Decide what each output should grant this cycle from the current inputs.
    function automatic void model_step();
        exp_grant = '0;
        for (int o = 0; o < NP; o++) begin
            exp_sel[o] = '0;
            if (rst) begin
                m_ptr[o]    = 0;
                m_locked[o] = 0;
                m_owner[o]  = 0;
            end else if (ready_v[o]) begin
                int win;
                win = -1;
                for (int k = 0; k < NP && win < 0; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % NP;
                    if (req_v[i][o] == 1'b1) begin
`ifdef SW_ALLOC_PKT_LOCK_EN
                        if (!m_locked[o] || m_owner[o] == i) win = i;
`else
                        win = i;
`endif
                    end
                end
                if (win >= 0) begin
                    exp_sel[o][win] = 1'b1;
                    exp_grant[win]  = 1'b1;
`ifdef SW_ALLOC_PKT_LOCK_EN
                    if (tail_v[win]) begin
                        m_locked[o] = 0;
                        m_ptr[o]    = (win + 1) % NP;
                    end else begin
                        m_locked[o] = 1;
                        m_owner[o]  = win;
                    end
`else
                    m_ptr[o] = (win + 1) % NP;
`endif
                end
            end
        end
    endfunction

    // Apply inputs, clock once, then compare every select and grant.
    task automatic tick(input string tag);
        drive();
        model_step();
        @(posedge clk);
        #1;
        obs_sel[0] = ifc.sel_for_OP0;
        obs_sel[1] = ifc.sel_for_OP1;
        obs_sel[2] = ifc.sel_for_OP2;
        obs_sel[3] = ifc.sel_for_OP3;
        obs_sel[4] = ifc.sel_for_OP4;
        obs_grant  = {ifc.grant_to_P4, ifc.grant_to_P3, ifc.grant_to_P2,
                      ifc.grant_to_P1, ifc.grant_to_P0};
        for (int o = 0; o < NP; o++) begin
            chk($sformatf("%s sel_for_OP%0d", tag, o), 32'(obs_sel[o]), 32'(exp_sel[o]));
        end
        chk($sformatf("%s grants", tag), 32'(obs_grant), 32'(exp_grant));
    endtask

    task automatic clear_req();
        for (int i = 0; i < NP; i++) req_v[i] = '0;
    endtask

    initial begin
        clear_req();
        tail_v  = '1;
        ready_v = '1;

        // Reset with live requests: nothing may be selected.
        for (int i = 0; i < NP; i++) req_v[i] = 5'b00001;
        rst = 1'b1;
        tick("reset0");
        tick("reset1");
        for (int o = 0; o < NP; o++) chk($sformatf("reset sel%0d", o), 32'(obs_sel[o]), 32'd0);
        chk("reset grant", 32'(obs_grant), 32'd0);
        rst = 1'b0;

        // Everybody wants OP2: grants rotate from port 0.
        begin
            logic [NP-1:0] rr_exp [6];
            rr_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
            for (int i = 0; i < NP; i++) req_v[i] = 5'b00100;
            for (int c = 0; c < 6; c++) begin
                tick($sformatf("rr%0d", c));
                chk($sformatf("rr seq%0d", c), 32'(obs_sel[2]), 32'(rr_exp[c]));
            end
        end

        // Backpressure on OP3.
        clear_req();
        req_v[1]   = 5'b01000;
        ready_v[3] = 1'b0;
        tick("bp_stall");
        chk("bp stall sel3", 32'(obs_sel[3]), 32'd0);
        ready_v = '1;
        tick("bp_go");
        chk("bp go sel3", 32'(obs_sel[3]), 32'b00010);
        chk("bp go grant1", 32'(obs_grant[1]), 32'd1);

        // Independent outputs in the same cycle.
        clear_req();
        req_v[0] = 5'b00010;
        req_v[1] = 5'b00001;
        req_v[4] = 5'b10000;
        tick("par");
        chk("par sel1", 32'(obs_sel[1]), 32'b00001);
        chk("par sel0", 32'(obs_sel[0]), 32'b00010);
        chk("par sel4", 32'(obs_sel[4]), 32'b10000);

`ifdef SW_ALLOC_PKT_LOCK_EN
        // 3-flit packet from P0 to OP1 with a bubble, P2 waiting behind it.
        clear_req();
        rst = 1'b1;
        tick("lk_rst");
        rst = 1'b0;
        req_v[0] = 5'b00010; req_v[2] = 5'b00010; tail_v = '0;
        tick("lk_head");
        chk("lk head", 32'(obs_sel[1]), 32'b00001);
        req_v[0] = '0;
        tick("lk_bubble");
        chk("lk bubble", 32'(obs_sel[1]), 32'd0);
        req_v[0] = 5'b00010;
        tick("lk_body");
        chk("lk body", 32'(obs_sel[1]), 32'b00001);
        tail_v[0] = 1'b1;
        tick("lk_tail");
        chk("lk tail", 32'(obs_sel[1]), 32'b00001);
        req_v[0] = '0; tail_v = '1;
        tick("lk_next");
        chk("lk next P2", 32'(obs_sel[1]), 32'b00100);
`endif

        // Reset in the middle of traffic (mid-packet when locking is built in).
        clear_req();
        req_v[0] = 5'b00010; req_v[2] = 5'b00010; tail_v = '0;
        tick("mr_pre");
        rst = 1'b1;
        tick("mr_rst");
        rst = 1'b0;
        req_v[0] = '0; tail_v = '1;
        tick("mr_post");
        chk("mr P2 sel1", 32'(obs_sel[1]), 32'b00100);
        chk("mr P2 grant", 32'(obs_grant[2]), 32'd1);

        // Random one-hot/zero traffic with occasional backpressure and resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                int pick;
                pick     = int'($urandom_range(0, NP + 1));
                req_v[i] = (pick < NP) ? (NP'(1) << pick) : '0;
                tail_v[i] = ($urandom_range(0, 2) != 0);
            end
            for (int o = 0; o < NP; o++) ready_v[o] = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            tick($sformatf("rnd%0d", c));
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
